debounce_keys_repeat: RTL and testbench
=======================================

Name: debounce_keys_repeat

Overview:
Multi-channel key conditioner for the board push-buttons and switches.
- Synchronises N raw inputs, normalises polarity and debounces each channel independently.
- Emits a level output plus one-cycle press, release and auto-repeat pulses per channel.
- Sits between the board KEY/SW pins and the game control FSMs, replacing ad-hoc per-key debounce and edge detection.

Parameters:
N, 4, number of independent channels
THRESHOLD, 10, consecutive differing synchronised samples required to flip a channel (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
ACTIVE_LOW, 1, 1 = raw input pressed when 0 (board KEYs); 0 = pressed when 1
REPEAT_DELAY, 25000000, cycles from press to first repeat pulse (>=1)
REPEAT_RATE, 5000000, cycles between subsequent repeat pulses (>=1)

Ports:
clock  in  1  system clock
resetn  in  1  asynchronous active-low reset
raw  in  N  raw pin inputs, asynchronous to clock
rep_en  in  N  per-channel auto-repeat enable
state  out  N  debounced level, active-high (1 = pressed)
pressed  out  N  one-cycle pulse on debounced 0->1
released  out  N  one-cycle pulse on debounced 1->0
repeat_pulse  out  N  one-cycle auto-repeat pulse
action  out  N  pressed | repeat_pulse

Behaviour:
- Reset: resetn is asynchronous, active-low. While low, all outputs are 0 immediately, with no clock edge needed.
- Reset values: debounce counters 0, repeat counters 0, repeat FSMs IDLE, synchroniser flops at the inactive raw level (ACTIVE_LOW ? 1 : 0).
- Sync: each raw bit passes through a SYNC_STAGES flop chain. Its output s is XORed with ACTIVE_LOW to give active-high s_n.
- Debounce, per channel, counter width $clog2(THRESHOLD+1):
  - If s_n == state: counter <= 0.
  - Else if counter == THRESHOLD-1: state <= s_n and counter <= 0.
  - Else: counter <= counter + 1.
  - Any bounce back to the current state level restarts the count.
- Latency: the new raw level is first captured at edge k. state flips at edge k+SYNC_STAGES+THRESHOLD-1 if raw is stable throughout.
- Pulse registers:
  - pressed is set on the same edge state goes 0->1; released is set on the same edge state goes 1->0.
  - Both are cleared next edge, so they are high exactly 1 cycle, coincident with the first cycle of the new state.
- Repeat FSM, per channel, states IDLE / HOLD_DELAY / HOLD_RATE; counter width fits max(REPEAT_DELAY, REPEAT_RATE).
  - IDLE -> HOLD_DELAY on the press edge; counter <= 0.
  - HOLD_DELAY: counter increments each cycle. When counter == REPEAT_DELAY-1: repeat_pulse for 1 cycle, counter <= 0, -> HOLD_RATE. First repeat is therefore at press edge + REPEAT_DELAY.
  - HOLD_RATE: same rule with REPEAT_RATE-1. Repeats every REPEAT_RATE cycles while held.
  - state == 0 or rep_en == 0 -> IDLE and counter <= 0. Reasserting rep_en while held restarts the full REPEAT_DELAY.
  - No repeat_pulse in the release cycle.
- action = pressed | repeat_pulse (combinational OR of registered signals).
- Channels are fully independent; simultaneous events on any channels produce simultaneous pulses.
- Reset mid-hold:
  - state returns to 0 and no released pulse is generated.
  - If the key is still held after reset release, pressed fires after normal debounce latency. Synchroniser flops are at the inactive level, so this counts from the first edge after release.
- THRESHOLD=1: state follows s_n with one cycle of delay, and still gives single-cycle pulses.

Test Plan:
Parameters for all tests: N=2, THRESHOLD=4, SYNC_STAGES=2, ACTIVE_LOW=1, REPEAT_DELAY=8, REPEAT_RATE=3. All raw bits idle high.
1. Async reset: drive resetn low between clock edges while state[0]=1 -> state, pressed, released, repeat_pulse and action all 0 before the next edge; they stay 0 while resetn is low.
2. Clean press, rep_en=0: raw[0] 1->0, first sampled at edge k -> state[0]=1 and pressed[0]=1 at edge k+5; pressed[0] returns to 0 at k+6. Raw back high at edge m -> released[0]=1 at m+5 for exactly 1 cycle.
3. Bounce: raw[0] low 3 cycles, high 1 cycle, then low held -> no output change during the bounce; state[0] rises 5 edges after the final low is first sampled. A 3-cycle low glitch alone never changes state.
4. Auto-repeat, rep_en[0]=1, held, pressed at edge P:
   - repeat_pulse[0] at P+8, P+11, P+14, ...
   - action[0] high at P, P+8, P+11, ...
   - After release, no repeats once state=0 and released[0] pulses once.
   - Dropping rep_en at P+9 then reasserting at P+12 gives the next repeat at P+20.
5. Simultaneous, rep_en=2'b01: raw 2'b11->2'b00 on the same edge -> pressed=2'b11 on the same cycle; only channel 0 produces repeat pulses.
6. Reset mid-hold: channel 0 held, pulse resetn low 2 cycles, key kept held -> no released[0]; pressed[0] re-fires 5 edges after the first post-reset sampling edge.

Source files
------------

// File: rtl/debounce_keys_repeat.sv
// Per-channel key conditioner: synchroniser, debouncer, press/release edges and auto-repeat.
// Latency: SYNC_STAGES+THRESHOLD-1 edges from first raw sample to state flip; no backpressure.
module debounce_keys_repeat #(
    parameter int N            = 4,
    parameter int THRESHOLD    = 10,
    parameter int SYNC_STAGES  = 2,
    parameter int ACTIVE_LOW   = 1,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic [N-1:0] raw,
    input  logic [N-1:0] rep_en,
    output logic [N-1:0] state,
    output logic [N-1:0] pressed,
    output logic [N-1:0] released,
    output logic [N-1:0] repeat_pulse,
    output logic [N-1:0] action
);

    localparam int   CW       = $clog2(THRESHOLD + 1);
    localparam int   RMAX     = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int   RW       = $clog2(RMAX + 1);
    localparam logic IDLE_LVL = 1'(ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        HOLD_DELAY = 2'd1,
        HOLD_RATE  = 2'd2
    } rep_st_t;

    logic [N-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [N-1:0][CW-1:0]          db_cnt_q, db_cnt_d;
    logic [N-1:0][RW-1:0]          rc_q, rc_d;
    logic [N-1:0]                  state_q, state_d;
    logic [N-1:0]                  pressed_q, pressed_d;
    logic [N-1:0]                  released_q, released_d;
    logic [N-1:0]                  rpt_q, rpt_d;
    logic [N-1:0]                  s_n;
    rep_st_t                       rs_q [N];
    rep_st_t                       rs_d [N];

    always_comb begin
        sync_d     = sync_q;
        db_cnt_d   = db_cnt_q;
        rc_d       = rc_q;
        state_d    = state_q;
        pressed_d  = '0;
        released_d = '0;
        rpt_d      = '0;
        s_n        = '0;
        rs_d       = rs_q;
        for (int i = 0; i < N; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], raw[i]};
            s_n[i]    = sync_q[i][SYNC_STAGES-1] ^ IDLE_LVL;

            // Any sample matching the current level restarts the count.
            if (s_n[i] == state_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == CW'(THRESHOLD - 1)) begin
                state_d[i]  = s_n[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end

            pressed_d[i]  = state_d[i] & ~state_q[i];
            released_d[i] = ~state_d[i] & state_q[i];

            // Decided on the next level so the release cycle never carries a repeat.
            if (!state_d[i] || !rep_en[i]) begin
                rs_d[i] = IDLE;
                rc_d[i] = '0;
            end else begin
                case (rs_q[i])
                    IDLE: begin
                        rs_d[i] = HOLD_DELAY;
                        rc_d[i] = '0;
                    end
                    HOLD_DELAY: begin
                        if (rc_q[i] == RW'(REPEAT_DELAY - 1)) begin
                            rpt_d[i] = 1'b1;
                            rc_d[i]  = '0;
                            rs_d[i]  = HOLD_RATE;
                        end else begin
                            rc_d[i] = rc_q[i] + 1'b1;
                        end
                    end
                    HOLD_RATE: begin
                        if (rc_q[i] == RW'(REPEAT_RATE - 1)) begin
                            rpt_d[i] = 1'b1;
                            rc_d[i]  = '0;
                        end else begin
                            rc_d[i] = rc_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        rs_d[i] = IDLE;
                        rc_d[i] = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_q     <= {(N*SYNC_STAGES){IDLE_LVL}};
            db_cnt_q   <= '0;
            rc_q       <= '0;
            state_q    <= '0;
            pressed_q  <= '0;
            released_q <= '0;
            rpt_q      <= '0;
            for (int i = 0; i < N; i++) begin
                rs_q[i] <= IDLE;
            end
        end else begin
            sync_q     <= sync_d;
            db_cnt_q   <= db_cnt_d;
            rc_q       <= rc_d;
            state_q    <= state_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            rpt_q      <= rpt_d;
            rs_q       <= rs_d;
        end
    end

    assign state        = state_q;
    assign pressed      = pressed_q;
    assign released     = released_q;
    assign repeat_pulse = rpt_q;
    assign action       = pressed_q | rpt_q;

endmodule

// File: tb/tb_debounce_keys_repeat.sv
// Bench for debounce_keys_repeat: timed expectations queued at stimulus, compared per cycle.
module tb_debounce_keys_repeat;

    logic       clock;
    logic       resetn;
    logic [1:0] raw;
    logic [1:0] rep_en;
    logic [1:0] state, pressed, released, repeat_pulse, action;

    int n_chk  = 0;
    int n_fail = 0;
    int edge_cnt = 0;

    typedef struct {
        int         cyc;
        logic [9:0] v;
        string      name;
    } exp_t;

    exp_t sb[$];

    debounce_keys_repeat #(
        .N(2), .THRESHOLD(4), .SYNC_STAGES(2), .ACTIVE_LOW(1),
        .REPEAT_DELAY(8), .REPEAT_RATE(3)
    ) dut (
        .clock(clock), .resetn(resetn), .raw(raw), .rep_en(rep_en),
        .state(state), .pressed(pressed), .released(released),
        .repeat_pulse(repeat_pulse), .action(action)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) edge_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, edges=%0d required completion", edge_cnt);
        $fatal(1);
    end

    // Expected {state, pressed, released, repeat_pulse, action} after edge c.
    function automatic void push_exp(string nm, int c, logic [1:0] st, logic [1:0] pr,
                                     logic [1:0] rl, logic [1:0] rp, logic [1:0] ac);
        exp_t e;
        e.cyc  = c;
        e.v    = {st, pr, rl, rp, ac};
        e.name = nm;
        sb.push_back(e);
    endfunction

    task automatic test_reset;
        resetn = 1'b0;
        raw    = 2'b11;
        rep_en = 2'b00;
        #3;
        n_chk++;
        if ({state, pressed, released, repeat_pulse, action} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_initial: got %b want %b", {state, pressed, released, repeat_pulse, action}, 10'd0);
        end
        @(negedge clock);
        resetn = 1'b1;
        repeat (8) @(negedge clock);
        n_chk++;
        if ({state, pressed, released, repeat_pulse, action} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_idle: got %b want %b", {state, pressed, released, repeat_pulse, action}, 10'd0);
        end
    endtask

    task automatic test_clean_press;
        int b;
        exp_t e;
        logic [9:0] obs;
        @(negedge clock);
        b = edge_cnt;
        push_exp("press_before", b + 5,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        push_exp("press_edge",   b + 6,  2'b01, 2'b01, 2'b00, 2'b00, 2'b01);
        push_exp("press_clear",  b + 7,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        push_exp("rel_before",   b + 15, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        push_exp("rel_edge",     b + 16, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        push_exp("rel_clear",    b + 17, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        for (int t = 0; t < 20; t++) begin
            if (t == 0)  raw[0] = 1'b0;
            if (t == 10) raw[0] = 1'b1;
            @(negedge clock);
            while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
                e = sb.pop_front();
                obs = {state, pressed, released, repeat_pulse, action};
                n_chk++;
                if (e.cyc != edge_cnt || obs !== e.v) begin
                    n_fail++;
                    $display("FAIL %s edge %0d: got %b want %b", e.name, edge_cnt, obs, e.v);
                end
            end
        end
    endtask

    task automatic test_async_reset;
        int b;
        exp_t e;
        logic [9:0] obs;
        @(negedge clock);
        b = edge_cnt;
        push_exp("ar_pressed", b + 6, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01);
        for (int t = 0; t < 8; t++) begin
            if (t == 0) raw[0] = 1'b0;
            @(negedge clock);
            while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
                e = sb.pop_front();
                obs = {state, pressed, released, repeat_pulse, action};
                n_chk++;
                if (e.cyc != edge_cnt || obs !== e.v) begin
                    n_fail++;
                    $display("FAIL %s edge %0d: got %b want %b", e.name, edge_cnt, obs, e.v);
                end
            end
        end
        n_chk++;
        if (state !== 2'b01) begin
            n_fail++;
            $display("FAIL ar_held: state got %b want 01", state);
        end
        @(posedge clock);
        #2 resetn = 1'b0;
        #1;
        n_chk++;
        if ({state, pressed, released, repeat_pulse, action} !== 10'd0) begin
            n_fail++;
            $display("FAIL ar_immediate: got %b want %b", {state, pressed, released, repeat_pulse, action}, 10'd0);
        end
        for (int t = 0; t < 2; t++) begin
            @(negedge clock);
            n_chk++;
            if ({state, pressed, released, repeat_pulse, action} !== 10'd0) begin
                n_fail++;
                $display("FAIL ar_held_low: got %b want %b", {state, pressed, released, repeat_pulse, action}, 10'd0);
            end
        end
        raw = 2'b11;
        @(negedge clock);
        resetn = 1'b1;
        repeat (8) @(negedge clock);
    endtask

    task automatic test_bounce;
        int b;
        exp_t e;
        logic [9:0] obs;
        @(negedge clock);
        b = edge_cnt;
        push_exp("bounce_mid",    b + 6,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        push_exp("bounce_wait",   b + 8,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        push_exp("bounce_before", b + 9,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        push_exp("bounce_press",  b + 10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01);
        push_exp("bounce_rel",    b + 20, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        push_exp("glitch_a",      b + 29, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        push_exp("glitch_b",      b + 30, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        push_exp("glitch_c",      b + 32, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        for (int t = 0; t < 35; t++) begin
            if (t == 0 || t == 4 || t == 24) raw[0] = 1'b0;
            if (t == 3 || t == 14 || t == 27) raw[0] = 1'b1;
            @(negedge clock);
            while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
                e = sb.pop_front();
                obs = {state, pressed, released, repeat_pulse, action};
                n_chk++;
                if (e.cyc != edge_cnt || obs !== e.v) begin
                    n_fail++;
                    $display("FAIL %s edge %0d: got %b want %b", e.name, edge_cnt, obs, e.v);
                end
            end
        end
    endtask

    task automatic test_repeat;
        int b, p;
        exp_t e;
        logic [9:0] obs;
        @(negedge clock);
        b = edge_cnt;
        p = b + 6;
        rep_en = 2'b01;
        push_exp("rpt_press",    p,      2'b01, 2'b01, 2'b00, 2'b00, 2'b01);
        push_exp("rpt_quiet",    p + 1,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        push_exp("rpt_early",    p + 7,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        push_exp("rpt_first",    p + 8,  2'b01, 2'b00, 2'b00, 2'b01, 2'b01);
        push_exp("rpt_one_cyc",  p + 9,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        push_exp("rpt_second",   p + 11, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01);
        push_exp("rpt_third",    p + 14, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01);
        push_exp("rpt_fourth",   p + 17, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01);
        push_exp("rpt_rel",      p + 20, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        push_exp("rpt_after",    p + 23, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        for (int t = 0; t < 32; t++) begin
            if (t == 0)  raw[0] = 1'b0;
            if (t == 20) raw[0] = 1'b1;
            @(negedge clock);
            while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
                e = sb.pop_front();
                obs = {state, pressed, released, repeat_pulse, action};
                n_chk++;
                if (e.cyc != edge_cnt || obs !== e.v) begin
                    n_fail++;
                    $display("FAIL %s edge %0d: got %b want %b", e.name, edge_cnt, obs, e.v);
                end
            end
        end
        rep_en = 2'b00;
    endtask

    task automatic test_rep_en_toggle;
        int b, p;
        exp_t e;
        logic [9:0] obs;
        @(negedge clock);
        b = edge_cnt;
        p = b + 6;
        rep_en = 2'b01;
        push_exp("tog_first",   p + 8,  2'b01, 2'b00, 2'b00, 2'b01, 2'b01);
        push_exp("tog_off_a",   p + 11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        push_exp("tog_off_b",   p + 14, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        push_exp("tog_off_c",   p + 17, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        push_exp("tog_early",   p + 19, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        push_exp("tog_restart", p + 20, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01);
        push_exp("tog_rate",    p + 23, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01);
        push_exp("tog_rel",     p + 25, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        for (int t = 0; t < 34; t++) begin
            if (t == 0)  raw[0] = 1'b0;
            if (t == 14) rep_en[0] = 1'b0;
            if (t == 17) rep_en[0] = 1'b1;
            if (t == 25) raw[0] = 1'b1;
            @(negedge clock);
            while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
                e = sb.pop_front();
                obs = {state, pressed, released, repeat_pulse, action};
                n_chk++;
                if (e.cyc != edge_cnt || obs !== e.v) begin
                    n_fail++;
                    $display("FAIL %s edge %0d: got %b want %b", e.name, edge_cnt, obs, e.v);
                end
            end
        end
        rep_en = 2'b00;
    endtask

    task automatic test_simultaneous;
        int b, p;
        exp_t e;
        logic [9:0] obs;
        @(negedge clock);
        b = edge_cnt;
        p = b + 6;
        rep_en = 2'b01;
        push_exp("sim_press",  p,      2'b11, 2'b11, 2'b00, 2'b00, 2'b11);
        push_exp("sim_rpt_a",  p + 8,  2'b11, 2'b00, 2'b00, 2'b01, 2'b01);
        push_exp("sim_rpt_b",  p + 11, 2'b11, 2'b00, 2'b00, 2'b01, 2'b01);
        push_exp("sim_rel",    p + 14, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
        for (int t = 0; t < 24; t++) begin
            if (t == 0)  raw = 2'b00;
            if (t == 14) raw = 2'b11;
            @(negedge clock);
            while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
                e = sb.pop_front();
                obs = {state, pressed, released, repeat_pulse, action};
                n_chk++;
                if (e.cyc != edge_cnt || obs !== e.v) begin
                    n_fail++;
                    $display("FAIL %s edge %0d: got %b want %b", e.name, edge_cnt, obs, e.v);
                end
            end
        end
        rep_en = 2'b00;
    endtask

    task automatic test_reset_mid_hold;
        int b;
        exp_t e;
        logic [9:0] obs;
        @(negedge clock);
        b = edge_cnt;
        push_exp("mh_held",     b + 9,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        push_exp("mh_in_rst",   b + 10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        push_exp("mh_in_rst2",  b + 11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        push_exp("mh_no_rel",   b + 12, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        push_exp("mh_before",   b + 16, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        push_exp("mh_repress",  b + 17, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01);
        push_exp("mh_rel",      b + 26, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        for (int t = 0; t < 30; t++) begin
            if (t == 0)  raw[0] = 1'b0;
            if (t == 9)  resetn = 1'b0;
            if (t == 11) resetn = 1'b1;
            if (t == 20) raw[0] = 1'b1;
            @(negedge clock);
            while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
                e = sb.pop_front();
                obs = {state, pressed, released, repeat_pulse, action};
                n_chk++;
                if (e.cyc != edge_cnt || obs !== e.v) begin
                    n_fail++;
                    $display("FAIL %s edge %0d: got %b want %b", e.name, edge_cnt, obs, e.v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_async_reset();
        test_bounce();
        test_repeat();
        test_rep_en_toggle();
        test_simultaneous();
        test_reset_mid_hold();
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left unchecked, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
